// File: rtl/usb_tx_framer_pkg.sv
// Shared types and constants for the low-speed USB transmit framer.
// Covers PID encodings, CRC16 constants, framer FSM states and PID classification helpers.
package usb_tx_framer_pkg;

  localparam int MAX_LEN_DEF    = 8;
  localparam int EOP_CYCLES_DEF = 64;

  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_R = 16'hA001;

  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_SOF   = 4'b0101,
    PID_SETUP = 4'b1101,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011
  } pid_t;

  typedef enum logic [2:0] {
    IDLE,
    PID,
    FETCH,
    DATA,
    CRC_LO,
    CRC_HI,
    DROP,
    HOLD
  } tx_framer_state_t;

  function automatic logic pid_is_handshake(input logic [3:0] p);
    return (p == PID_ACK) || (p == PID_NAK) || (p == PID_STALL);
  endfunction

  function automatic logic pid_is_data(input logic [3:0] p);
    return (p == PID_DATA0) || (p == PID_DATA1);
  endfunction

endpackage

// File: rtl/usb_tx_framer_crc16.sv
// One-byte update of the USB CRC16 (reflected polynomial 0xA001), LSB of the byte first.
// Purely combinational: eight LFSR steps unrolled in a single cycle.
module usb_crc16_byte
  import usb_tx_framer_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  d_i,
  output logic [15:0] crc_o
);

  logic [15:0] c;

  always_comb begin
    c = crc_i;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ (((c[0] ^ d_i[i]) == 1'b1) ? CRC16_POLY_R : 16'h0000);
    end
    crc_o = c;
  end

endmodule

// File: rtl/usb_tx_framer.sv
// Low-speed device transmit framer: emits PID, optional payload from the endpoint RAM and CRC16,
// then waits out the EOP before pulsing done.
module usb_tx_framer
  import usb_tx_framer_pkg::*;
#(
  parameter int MAX_LEN    = MAX_LEN_DEF,
  parameter int EOP_CYCLES = EOP_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] pid,
  input  logic [3:0] len,
  output logic [2:0] buf_addr,
  input  logic [7:0] buf_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int HOLD_W = (EOP_CYCLES > 2) ? $clog2(EOP_CYCLES) : 1;

  tx_framer_state_t state_q, state_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic [2:0]        buf_addr_q, buf_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [15:0]       crc_q, crc_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        len_q, len_d;
  logic              data_pkt_q, data_pkt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [15:0] crc_next;
  logic        is_hs;
  logic        is_dat;
  logic        len_ok;

  usb_crc16_byte u_crc (
    .crc_i (crc_q),
    .d_i   (buf_data),
    .crc_o (crc_next)
  );

  assign is_hs  = pid_is_handshake(pid);
  assign is_dat = pid_is_data(pid);
  assign len_ok = int'(len) <= MAX_LEN;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    buf_addr_d = buf_addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    data_pkt_d = data_pkt_q;
    hold_d     = hold_q;

    unique case (state_q)
      IDLE: begin
        // A start landing on the done pulse belongs to the finished packet's cycle and is dropped.
        if (start && !done_q) begin
          if (is_hs || (is_dat && len_ok)) begin
            tx_data_d  = {~pid, pid};
            tx_valid_d = 1'b1;
            busy_d     = 1'b1;
            crc_d      = CRC16_INIT;
            cnt_d      = 4'd0;
            len_d      = len;
            data_pkt_d = is_dat;
            if (is_dat && (len != 4'd0)) buf_addr_d = 3'd0;
            state_d    = PID;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PID: begin
        if (tx_ready) begin
          if (!data_pkt_q) begin
            state_d = DROP;
          end else if (len_q == 4'd0) begin
            tx_data_d = ~crc_q[7:0];
            state_d   = CRC_LO;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        tx_data_d  = buf_data;
        crc_d      = crc_next;
        buf_addr_d = buf_addr_q + 3'd1;
        state_d    = DATA;
      end
      DATA: begin
        if (tx_ready) begin
          if (cnt_q + 4'd1 == len_q) begin
            tx_data_d = ~crc_q[7:0];
            state_d   = CRC_LO;
          end else begin
            cnt_d   = cnt_q + 4'd1;
            state_d = FETCH;
          end
        end
      end
      CRC_LO: begin
        if (tx_ready) begin
          tx_data_d = ~crc_q[15:8];
          state_d   = CRC_HI;
        end
      end
      CRC_HI: begin
        if (tx_ready) state_d = DROP;
      end
      DROP: begin
        tx_valid_d = 1'b0;
        hold_d     = HOLD_W'(EOP_CYCLES - 1);
        state_d    = HOLD;
      end
      HOLD: begin
        if (hold_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
    if (reset) begin
      state_q    <= IDLE;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      buf_addr_q <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      crc_q      <= CRC16_INIT;
      cnt_q      <= 4'd0;
      len_q      <= 4'd0;
      data_pkt_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      buf_addr_q <= buf_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      data_pkt_q <= data_pkt_d;
      hold_q     <= hold_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign buf_addr = buf_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
